// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: FIFO-buffered stereo I2S transmitter with bclk/lrclk divided from clk.
// Build option DAC_HOLD_ON_UNDERRUN_EN: underrun frames repeat the last popped pair instead of zeros.
module audio_dac_serializer #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_ADDR_W = 2,
  parameter int BCLK_DIV    = 8,
  parameter int SLOT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_left,
  input  logic [DATA_WIDTH-1:0] data_right,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_ADDR_W:0]  fill_level,
  output logic                  overflow,
  output logic                  underrun,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata
);
  localparam int DEPTH = 2 ** FIFO_ADDR_W;
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int CW    = $clog2(BCLK_DIV + 1);
  localparam int BW    = $clog2(FRAME);
  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt, bit_nxt, pos;
  logic [DATA_WIDTH-1:0]   l_sr, r_sr, fill_l, fill_r, load_l, load_r;
  logic                    wrap, fe, frame_start, pop, push, right, in_word;
  assign full  = fill_level[FIFO_ADDR_W];
  assign empty = fill_level == '0;
  always_comb begin
    wrap        = run && div_cnt == CW'(BCLK_DIV - 1);
    fe          = wrap && bclk;
    frame_start = fe && bit_cnt == BW'(FRAME - 1);
    pop         = frame_start && !empty;
    push        = wr && (!full || pop);
    bit_nxt     = frame_start ? '0 : bit_cnt + BW'(1);
    right       = bit_nxt >= BW'(SLOT_BITS);
    pos         = right ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;
    in_word     = pos != '0 && pos <= BW'(DATA_WIDTH);
    load_l      = pop ? mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH] : fill_l;
    load_r      = pop ? mem[rd_ptr][DATA_WIDTH-1:0] : fill_r;
  end
`ifdef DAC_HOLD_ON_UNDERRUN_EN
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) {hold_l, hold_r} <= '0;
    else if (pop) {hold_l, hold_r} <= mem[rd_ptr];
  assign fill_l = hold_l;
  assign fill_r = hold_r;
`else
  assign fill_l = '0;
  assign fill_r = '0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {data_left, data_right};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= BW'(FRAME - 1);
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      l_sr       <= '0;
      r_sr       <= '0;
    end else begin
      wr_ptr     <= push ? wr_ptr + FIFO_ADDR_W'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + FIFO_ADDR_W'(1) : rd_ptr;
      fill_level <= push && !pop ? fill_level + (FIFO_ADDR_W+1)'(1) :
                    pop && !push ? fill_level - (FIFO_ADDR_W+1)'(1) : fill_level;
      overflow   <= wr && !push;
      underrun   <= frame_start && empty;
      // bit_cnt parks on the last position so the first falling edge after run rises starts a frame
      if (!run) begin
        div_cnt <= '0;
        bit_cnt <= BW'(FRAME - 1);
        bclk    <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= 1'b0;
        l_sr    <= '0;
        r_sr    <= '0;
      end else begin
        div_cnt <= wrap ? '0 : div_cnt + CW'(1);
        bclk    <= bclk ^ wrap;
        if (fe) begin
          bit_cnt <= bit_nxt;
          lrclk   <= right;
          sdata   <= in_word && (right ? r_sr[DATA_WIDTH-1] : l_sr[DATA_WIDTH-1]);
          if (frame_start) begin
            l_sr <= load_l;
            r_sr <= load_r;
          end else if (in_word && right) r_sr <= r_sr << 1;
          else if (in_word) l_sr <= l_sr << 1;
        end
      end
    end
  end
endmodule
